// File: rtl/serial_add_seq_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
// The unused code 2'd3 is not named; the FSM treats it as a request to return to idle.
package serial_add_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand/result bundle between the issuing controller (master) and the serial adder (slave).
// Handshake: start is a request that is accepted only at an edge where the adder is idle or done.
// a/b/ci matter only at that edge. done pulses for one cycle, and s/co stay valid until the next completion.
interface serial_add_seq_if
   import serial_add_seq_pkg::*;
#(
   parameter int WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             co;
   state_t           state;

   modport master (
      output start, a, b, ci,
      input  busy, done, s, co, state
   );

   modport slave (
      input  start, a, b, ci,
      output busy, done, s, co, state
   );

endinterface

// File: rtl/serial_add_seq_add1.sv
// One-bit full adder used on the bit-0 datapath of the serial adder.
module add1 (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: latches the operands on start, adds one bit pair per clock (LSB first)
// with a registered carry, and publishes {co,s} together with a one-cycle done pulse.
module serial_add_seq
   import serial_add_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clrn,
   serial_add_seq_if.slave  bus
);

   localparam int              CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic             accept;
   logic             last_bit;

   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH-1:0] s_q;
   logic             carry;
   logic             co_q;
   logic [CW-1:0]    cnt;

   logic             add_s;
   logic             add_co;

   add1 u_add1 (
      .a  (ra[0]),
      .b  (rb[0]),
      .ci (carry),
      .s  (add_s),
      .co (add_co)
   );

   // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
   generate
      if (WIDTH == 1) begin : g_sum_w1
         assign sum_next = add_s;
      end else begin : g_sum_wn
         assign sum_next = {add_s, sum_sr[WIDTH-1:1]};
      end
   endgenerate

   assign last_bit = (cnt == LAST);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_bit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // s/co are only written on the last bit, so partial sums never reach the outputs.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ra     <= '0;
         rb     <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         s_q    <= '0;
         co_q   <= 1'b0;
      end else if (accept) begin
         ra    <= bus.a;
         rb    <= bus.b;
         carry <= bus.ci;
         cnt   <= '0;
      end else if (state_q == ST_RUN) begin
         ra     <= ra >> 1;
         rb     <= rb >> 1;
         carry  <= add_co;
         sum_sr <= sum_next;
         cnt    <= cnt + 1'b1;
         if (last_bit) begin
            s_q  <= sum_next;
            co_q <= add_co;
         end
      end
   end

   assign bus.busy  = (state_q == ST_RUN);
   assign bus.done  = (state_q == ST_DONE);
   assign bus.s     = s_q;
   assign bus.co    = co_q;
   assign bus.state = state_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq at WIDTH=8: directed cases, ignored/back-to-back starts,
// mid-run reset and random operands, with a queue of expected {co,s} results.
module tb_serial_add_seq;
   import serial_add_seq_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic clrn;
   always #5 clk = ~clk;

   serial_add_seq_if #(.WIDTH(W)) bus ();

   serial_add_seq #(.WIDTH(W)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   logic [W:0] exp_q[$];
   logic [W:0] last_exp;
   logic [W:0] mon_e;
   int         tests = 0;
   int         fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
   endfunction

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.ci    = ci;
      exp_q.push_back(model(a, b, ci));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.ci    = 1'($urandom);
   endtask

   // Counts negedges after the accept edge until done; done is expected on the WIDTH+1-th.
   task automatic wait_done(input string tag);
      int  n    = 0;
      int  nb   = 0;
      bit  seen = 1'b0;
      for (int i = 1; i <= 4 * W && !seen; i++) begin
         @(negedge clk);
         if (bus.busy) nb++;
         if (bus.done) begin
            seen = 1'b1;
            n    = i;
         end
      end
      check({tag, "_lat"}, 32'(n), 32'(W + 1));
      check({tag, "_busy"}, 32'(nb), 32'(W));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  32'(bus.busy),  32'(0));
      check({tag, "_done"},  32'(bus.done),  32'(0));
      check({tag, "_s"},     32'(bus.s),     32'(0));
      check({tag, "_co"},    32'(bus.co),    32'(0));
      check({tag, "_state"}, 32'(bus.state), 32'(ST_IDLE));
   endtask

   // Result monitor: pops on every done, otherwise the published result must hold.
   always @(negedge clk) begin
      if (clrn === 1'b1) begin
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'(1), 32'(0));
            end else begin
               mon_e = exp_q.pop_front();
               check("sum", 32'({bus.co, bus.s}), 32'(mon_e));
               last_exp = mon_e;
            end
         end else begin
            check("hold", 32'({bus.co, bus.s}), 32'(last_exp));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      clrn      = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.ci    = 1'b0;
      last_exp  = '0;

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      @(posedge clk);
      #2 clrn = 1'b1;

      start_op(8'h5A, 8'h3C, 1'b0);
      wait_done("op5a3c");
      start_op(8'hFF, 8'h01, 1'b0);
      wait_done("opff01");
      start_op(8'hFF, 8'hFF, 1'b1);
      wait_done("opffff");
      start_op(8'h00, 8'h00, 1'b1);
      wait_done("op0000");

      // start held with new operands during RUN must not disturb the first result;
      // it is then accepted in DONE.
      start_op(8'h11, 8'h22, 1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h77;
      bus.b     = 8'h88;
      bus.ci    = 1'b1;
      seen      = 1'b0;
      for (int i = 0; i < 4 * W && !seen; i++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      check("ign_done_seen", 32'(seen), 32'(1));
      exp_q.push_back(model(8'h77, 8'h88, 1'b1));
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done("b2b");

      // Reset in the middle of a run clears everything at once.
      start_op(8'hAB, 8'hCD, 1'b1);
      repeat (4) @(negedge clk);
      #2;
      clrn = 1'b0;
      exp_q.delete();
      last_exp = '0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      #2 clrn = 1'b1;
      start_op(8'h0F, 8'h01, 1'b0);
      wait_done("postrst");

      for (int k = 0; k < 200; k++) begin
         start_op(W'($urandom), W'($urandom), 1'($urandom));
         wait_done("rnd");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      @(negedge clk);
      check("q_empty", 32'(exp_q.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
